// File: rtl/scarv_mem_pkg.sv
// Shared definitions for the SCARV RAM arbiter: per-port response tracking states.
package scarv_mem_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_LIVE = 2'd1,
        RSP_HELD = 2'd2
    } rsp_state_e;

    function automatic logic rsp_pending(input rsp_state_e state);
        return (state != RSP_IDLE);
    endfunction

endpackage

// File: rtl/scarv_ram_rsp_slot.sv
// Per-port response tracker: forwards RAM data live, or parks it in a hold
// register while the requester back-pressures.
module scarv_ram_rsp_slot
    import scarv_mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gnt,
    input  logic             rsp_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rdata
);

    rsp_state_e       state_r;
    rsp_state_e       state_s;
    logic [WIDTH-1:0] hold_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RSP_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the RAM word on the first stalled cycle; mem_rdata may change afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= '0;
        end else if ((state_r == RSP_LIVE) && !rsp_ready) begin
            hold_r <= mem_rdata;
        end
    end

    // Next-state logic; a grant is only possible when no stalled response is pending
    always_comb begin
        state_s = state_r;
        case (state_r)
            RSP_IDLE: begin
                if (gnt) state_s = RSP_LIVE;
                else     state_s = RSP_IDLE;
            end
            RSP_LIVE, RSP_HELD: begin
                if (!rsp_ready) state_s = RSP_HELD;
                else if (gnt)   state_s = RSP_LIVE;
                else            state_s = RSP_IDLE;
            end
            default: state_s = RSP_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rsp_valid = rsp_pending(state_r);
        case (state_r)
            RSP_LIVE: rdata = mem_rdata;
            RSP_HELD: rdata = hold_r;
            RSP_IDLE: rdata = hold_r;
            default:  rdata = hold_r;
        endcase
    end

endmodule

// File: rtl/scarv_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM,
// with per-port response buffering so a stalled requester never blocks the other.
module scarv_ram_arbiter
    import scarv_mem_pkg::*;
#(
    parameter  int DEPTH = 4096,
    parameter  int WIDTH = 32,
    localparam int SW    = WIDTH / 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             a_req,
    output logic             a_gnt,
    input  logic             a_wen,
    input  logic [SW-1:0]    a_strb,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic [AW-1:0]    a_addr,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    output logic             b_gnt,
    input  logic             b_wen,
    input  logic [SW-1:0]    b_strb,
    input  logic [WIDTH-1:0] b_wdata,
    input  logic [AW-1:0]    b_addr,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [WIDTH-1:0] b_rdata,
    output logic             mem_cen,
    output logic             mem_wen,
    output logic [SW-1:0]    mem_strb,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic a_elig_s;
    logic b_elig_s;
    logic last_b_r;

    // Reset gates eligibility so nothing reaches the RAM while it is asserted
    assign a_elig_s = a_req && !g_reset && !(a_rsp_valid && !a_rsp_ready);
    assign b_elig_s = b_req && !g_reset && !(b_rsp_valid && !b_rsp_ready);

    // Grant selection: contention goes to the port not served most recently
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (a_elig_s && b_elig_s) begin
            if (last_b_r) a_gnt = 1'b1;
            else          b_gnt = 1'b1;
        end else if (a_elig_s) begin
            a_gnt = 1'b1;
        end else if (b_elig_s) begin
            b_gnt = 1'b1;
        end else begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    // Round-robin pointer; reset value makes A win the first contention
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            last_b_r <= 1'b1;
        end else if (a_gnt || b_gnt) begin
            last_b_r <= b_gnt;
        end
    end

    // RAM request mux, zeroed when idle
    always_comb begin
        mem_cen   = a_gnt || b_gnt;
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_wdata = '0;
        mem_addr  = '0;
        if (a_gnt) begin
            mem_wen   = a_wen;
            mem_strb  = a_strb;
            mem_wdata = a_wdata;
            mem_addr  = a_addr;
        end else if (b_gnt) begin
            mem_wen   = b_wen;
            mem_strb  = b_strb;
            mem_wdata = b_wdata;
            mem_addr  = b_addr;
        end else begin
            mem_wen   = 1'b0;
        end
    end

    scarv_ram_rsp_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk       (g_clk),
        .rst       (g_reset),
        .gnt       (a_gnt),
        .rsp_ready (a_rsp_ready),
        .mem_rdata (mem_rdata),
        .rsp_valid (a_rsp_valid),
        .rdata     (a_rdata)
    );

    scarv_ram_rsp_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk       (g_clk),
        .rst       (g_reset),
        .gnt       (b_gnt),
        .rsp_ready (b_rsp_ready),
        .mem_rdata (mem_rdata),
        .rsp_valid (b_rsp_valid),
        .rdata     (b_rdata)
    );

endmodule

// File: tb/tb_scarv_ram_arbiter.sv
// Directed bench for scarv_ram_arbiter with a small behavioural RAM behind it.
module tb_scarv_ram_arbiter;

    localparam int DEPTH = 64;
    localparam int WIDTH = 32;
    localparam int SW    = WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             a_req, a_gnt, a_wen, a_rsp_valid, a_rsp_ready;
    logic [SW-1:0]    a_strb;
    logic [WIDTH-1:0] a_wdata, a_rdata;
    logic [AW-1:0]    a_addr;
    logic             b_req, b_gnt, b_wen, b_rsp_valid, b_rsp_ready;
    logic [SW-1:0]    b_strb;
    logic [WIDTH-1:0] b_wdata, b_rdata;
    logic [AW-1:0]    b_addr;
    logic             mem_cen, mem_wen;
    logic [SW-1:0]    mem_strb;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;

    logic [WIDTH-1:0] ram [0:DEPTH-1];
    logic             ram_init;
    int               checks = 0;
    int               errors = 0;

    scarv_ram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .g_clk(clk), .g_reset(rst),
        .a_req(a_req), .a_gnt(a_gnt), .a_wen(a_wen), .a_strb(a_strb), .a_wdata(a_wdata),
        .a_addr(a_addr), .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rdata(a_rdata),
        .b_req(b_req), .b_gnt(b_gnt), .b_wen(b_wen), .b_strb(b_strb), .b_wdata(b_wdata),
        .b_addr(b_addr), .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rdata(b_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: word i initialised to 0xA5000000 | i, read data one cycle after cen
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA500_0000 | i;
            mem_rdata <= 32'h0;
        end else if (mem_cen) begin
            for (int j = 0; j < SW; j++)
                if (mem_wen && mem_strb[j]) ram[mem_addr][j*8 +: 8] <= mem_wdata[j*8 +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ram_init = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        #1;
        checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL reset_a_gnt got %b exp 0", a_gnt); end
        checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL reset_b_gnt got %b exp 0", b_gnt); end
        checks++; if (mem_cen !== 1'b0) begin errors++; $display("FAIL reset_mem_cen got %b exp 0", mem_cen); end
        checks++; if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b%b exp 00", a_rsp_valid, b_rsp_valid); end
        checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", a_rdata, b_rdata); end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0; rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        a_req = 1'b1; a_wen = 1'b0; a_addr = 6'h10;
        #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL single_gnt got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt); end
        checks++; if (mem_cen !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 6'h10) begin errors++; $display("FAIL single_mem got cen=%b wen=%b addr=%h exp 1 0 10", mem_cen, mem_wen, mem_addr); end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_0010) begin errors++; $display("FAIL single_rsp got v=%b d=%h exp 1 a5000010", a_rsp_valid, a_rdata); end
        checks++; if (mem_cen !== 1'b0 || mem_addr !== 6'h0) begin errors++; $display("FAIL single_idle_mem got cen=%b addr=%h exp 0 0", mem_cen, mem_addr); end
        @(negedge clk);
        #1;
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_clear got %b exp 0", a_rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic             exp_a;
        logic [AW-1:0]    exp_addr;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_req = 1'b1; b_req = 1'b1; a_wen = 1'b0; b_wen = 1'b0;
            a_addr = 6'(i); b_addr = 6'(i + 32);
            #1;
            exp_a    = (i % 2 == 0);
            exp_addr = exp_a ? 6'(i) : 6'(i + 32);
            checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin errors++; $display("FAIL rr_gnt%0d got a=%b b=%b exp a=%b", i, a_gnt, b_gnt, exp_a); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", i, mem_addr, exp_addr); end
            if (i == 1) begin
                checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_0000) begin errors++; $display("FAIL rr_rsp_a got v=%b d=%h exp 1 a5000000", a_rsp_valid, a_rdata); end
            end else if (i == 2) begin
                checks++; if (b_rsp_valid !== 1'b1 || b_rdata !== 32'hA500_0021) begin errors++; $display("FAIL rr_rsp_b got v=%b d=%h exp 1 a5000021", b_rsp_valid, b_rdata); end
            end
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        #1;
        exp_d = 32'hA500_0023;
        checks++; if (b_rsp_valid !== 1'b1 || b_rdata !== exp_d || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_last_rsp got bv=%b bd=%h av=%b exp 1 %h 0", b_rsp_valid, b_rdata, a_rsp_valid, exp_d); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_req = 1'b1; a_wen = 1'b1; a_strb = 4'hF; a_wdata = 32'hDEAD_BEEF; a_addr = 6'd5;
        #1;
        checks++; if (a_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_strb !== 4'hF || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_write got gnt=%b wen=%b strb=%h wd=%h", a_gnt, mem_wen, mem_strb, mem_wdata); end
        @(negedge clk);
        a_wen = 1'b0; a_addr = 6'd5;
        #1;
        checks++; if (a_gnt !== 1'b1 || a_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_read_gnt got gnt=%b v=%b exp 1 1", a_gnt, a_rsp_valid); end
        @(negedge clk);
        a_wen = 1'b1; a_strb = 4'b0011; a_wdata = 32'h1234_5678; a_addr = 6'd6;
        #1;
        checks++; if (a_gnt !== 1'b1 || a_rsp_valid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_readback got gnt=%b v=%b d=%h exp 1 1 deadbeef", a_gnt, a_rsp_valid, a_rdata); end
        @(negedge clk);
        a_wen = 1'b0; a_addr = 6'd6;
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL b2b_strb_read_gnt got %b exp 1", a_gnt); end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_5678) begin errors++; $display("FAIL b2b_partial_strb got v=%b d=%h exp 1 a5005678", a_rsp_valid, a_rdata); end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] exp_b;
        @(negedge clk);
        a_req = 1'b1; a_wen = 1'b0; a_addr = 6'd7; a_rsp_ready = 1'b0; b_req = 1'b0;
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL stall_first_gnt got %b exp 1", a_gnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_addr = 6'd8; b_req = 1'b1; b_wen = 1'b0; b_addr = 6'(10 + i); b_rsp_ready = 1'b1;
            #1;
            checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin errors++; $display("FAIL stall_gnt%0d got a=%b b=%b exp a=0 b=1", i, a_gnt, b_gnt); end
            checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_0007) begin errors++; $display("FAIL stall_hold%0d got v=%b d=%h exp 1 a5000007", i, a_rsp_valid, a_rdata); end
            if (i > 0) begin
                exp_b = 32'hA500_0000 | (10 + i - 1);
                checks++; if (b_rsp_valid !== 1'b1 || b_rdata !== exp_b) begin errors++; $display("FAIL stall_b_rsp%0d got v=%b d=%h exp 1 %h", i, b_rsp_valid, b_rdata, exp_b); end
            end
        end
        @(negedge clk);
        a_rsp_ready = 1'b1; b_addr = 6'd13;
        #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL stall_release_gnt got a=%b b=%b exp a=1 b=0", a_gnt, b_gnt); end
        checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_0007 || b_rdata !== 32'hA500_000C) begin errors++; $display("FAIL stall_release_rsp got v=%b a=%h b=%h", a_rsp_valid, a_rdata, b_rdata); end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_0008 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_after got av=%b ad=%h bv=%b exp 1 a5000008 0", a_rsp_valid, a_rdata, b_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_req = 1'b1; a_wen = 1'b0; a_addr = 6'd3; a_rsp_ready = 1'b1; b_req = 1'b0;
        #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", a_gnt); end
        @(negedge clk);
        rst = 1'b1; a_req = 1'b1; b_req = 1'b1; b_addr = 6'd4;
        #1;
        checks++; if (a_rsp_valid !== 1'b0 || mem_cen !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got v=%b cen=%b a=%b b=%b exp 0", a_rsp_valid, mem_cen, a_gnt, b_gnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got a=%b b=%b v=%b exp 1 0 0", a_gnt, b_gnt, a_rsp_valid); end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        #1;
        checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hA500_0003 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_new_rsp got av=%b ad=%h bv=%b", a_rsp_valid, a_rdata, b_rsp_valid); end
    endtask

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        a_req = 1'b0; a_wen = 1'b0; a_strb = 4'h0; a_wdata = 32'h0; a_addr = 6'h0; a_rsp_ready = 1'b1;
        b_req = 1'b0; b_wen = 1'b0; b_strb = 4'h0; b_wdata = 32'h0; b_addr = 6'h0; b_rsp_ready = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
